// File: rtl/seq_multiplier_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// One add/shift step per clock, fixed latency of WIDTH+1 cycles after start.
module seq_multiplier_param #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               tc,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] res,
   output logic               done,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic                 neg_q, neg_d;
   logic [2*WIDTH-1:0]   res_q, res_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;

   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       sum;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      res_d   = res_q;
      done_d  = 1'b0;
      busy_d  = busy_q;

      a_mag = (tc && A[WIDTH-1]) ? -A : A;
      b_mag = (tc && B[WIDTH-1]) ? -B : B;
      // Upper half plus multiplicand; the extra bit is the carry shifted back in.
      sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};

      unique case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = a_mag;
               acc_d   = {{WIDTH{1'b0}}, b_mag};
               neg_d   = tc & (A[WIDTH-1] ^ B[WIDTH-1]);
               cnt_d   = CNT_INIT;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_q[0] ? {sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = FIX;
            end
         end
         FIX: begin
            res_d   = neg_q ? -acc_q : acc_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign res  = res_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule
